// File: rtl/mux_seq_sel_if.sv
// rtl/mux_seq_sel_if.sv - channel inputs and registered output slot of mux_seq_sel
interface mux_seq_sel_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic          en;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] din;
  logic [N-1:0]  din_valid;
  logic [N-1:0]  din_taken;
  logic [W-1:0]  dout;
  logic [SW-1:0] dout_ch;
  logic          dout_valid;
  logic          dout_ready;

  modport master (
    output en, mode, sel, din, din_valid, dout_ready,
    input  din_taken, dout, dout_ch, dout_valid
  );

  modport slave (
    input  en, mode, sel, din, din_valid, dout_ready,
    output din_taken, dout, dout_ch, dout_valid
  );
endinterface

// File: rtl/mux_seq_sel.sv
// rtl/mux_seq_sel.sv - N-channel selector into a single registered output slot
// Define MUX_SEQ_SEL_SKIP_EMPTY_EN to make scan mode skip channels without valid data.
module mux_seq_sel #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_seq_sel_if.slave  bus
);
  localparam int SW = $clog2(N);

  logic [W-1:0]  ch_data [N];
  logic [SW-1:0] ptr;
  logic [SW-1:0] cand;
  logic          cand_ok;
  logic          can_load;
  logic          load;

  logic [N-1:0]  din_taken_q;
  logic [W-1:0]  dout_q;
  logic [SW-1:0] dout_ch_q;
  logic          dout_valid_q;

  for (genvar i = 0; i < N; i++) begin : g_split
    assign ch_data[i] = bus.din[i*W +: W];
  end

`ifdef MUX_SEQ_SEL_SKIP_EMPTY_EN
  // Scan starts at ptr and takes the first valid channel in rotating order.
  logic [SW-1:0] scan_idx;
  always_comb begin
    cand     = bus.sel;
    cand_ok  = 1'b0;
    scan_idx = '0;
    if (bus.mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        scan_idx = ptr + SW'(k);
        if (bus.din_valid[scan_idx]) begin
          cand    = scan_idx;
          cand_ok = 1'b1;
        end
      end
    end else begin
      cand_ok = bus.din_valid[bus.sel];
    end
  end
`else
  always_comb begin
    cand    = bus.mode ? ptr : bus.sel;
    cand_ok = bus.din_valid[cand];
  end
`endif

  assign can_load = !dout_valid_q || bus.dout_ready;
  assign load     = can_load && bus.en && cand_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_taken_q  <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      ptr          <= '0;
    end else begin
      din_taken_q <= load ? ({{(N-1){1'b0}}, 1'b1} << cand) : '0;

      if (load) begin
        dout_q       <= ch_data[cand];
        dout_ch_q    <= cand;
        dout_valid_q <= 1'b1;
      end else if (dout_valid_q && bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end

`ifdef MUX_SEQ_SEL_SKIP_EMPTY_EN
      if (bus.mode && load) begin
        ptr <= cand + 1'b1;
      end
`else
      // Plain scan keeps walking on every loadable cycle, even past empty channels.
      if (bus.mode && bus.en && can_load) begin
        ptr <= ptr + 1'b1;
      end
`endif
    end
  end

  assign bus.din_taken  = din_taken_q;
  assign bus.dout       = dout_q;
  assign bus.dout_ch    = dout_ch_q;
  assign bus.dout_valid = dout_valid_q;
endmodule
